// File: rtl/video_scan_pkg.sv
// rtl/video_scan_pkg.sv - shared types, defaults and helpers for the bitmap scan-out engine
//
// Purpose : default 640x480 timing, colour type and defaults, pipeline control
//           record and small elaboration-time helpers.
// Ports   : none (package).
package video_scan_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef logic [23:0] rgb_t;

  localparam rgb_t DEF_FG_RGB = 24'h3465A4;
  localparam rgb_t DEF_BG_RGB = 24'h2D0922;

  // Control bits travelling alongside the memory read through the latency line.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic fs;
    logic fetch;
    logic hit;
  } pipe_ctl_t;

  function automatic int timing_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int words_per_line(input int h_active, input int word_w, input int scale_x);
    return h_active / (word_w * scale_x);
  endfunction

  // One spare code so that "total" itself is representable in compares.
  function automatic int cnt_width(input int total);
    return $clog2(total + 1);
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - x/y raster counters with sync, active and frame-start decode
//
// Purpose : free-running pixel/line counters and their combinational decodes.
// Ports   : i_clk, i_rst (async, active-high)
//           o_x, o_y    current counter state
//           o_active    x < H_ACTIVE and y < V_ACTIVE
//           o_hsync     inside horizontal sync window (active-high, unpolarised)
//           o_vsync     inside vertical sync window (active-high, unpolarised)
//           o_first     counter is at (0,0)
module video_timing_gen
  import video_scan_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int XW       = cnt_width(timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
  parameter int YW       = cnt_width(timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
  input  logic          i_clk,
  input  logic          i_rst,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_active,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_first
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (r_x == XW'(H_TOTAL - 1)) begin
      r_x <= '0;
      r_y <= (r_y == YW'(V_TOTAL - 1)) ? '0 : r_y + YW'(1);
    end else begin
      r_x <= r_x + XW'(1);
    end
  end

  assign o_x      = r_x;
  assign o_y      = r_y;
  assign o_active = (r_x < XW'(H_ACTIVE)) && (r_y < YW'(V_ACTIVE));
  assign o_hsync  = (r_x >= XW'(H_ACTIVE + H_FP)) && (r_x < XW'(H_ACTIVE + H_FP + H_SYNC));
  assign o_vsync  = (r_y >= YW'(V_ACTIVE + V_FP)) && (r_y < YW'(V_ACTIVE + V_FP + V_SYNC));
  assign o_first  = (r_x == '0) && (r_y == '0);

endmodule

// File: rtl/bitmap_scanout.sv
// rtl/bitmap_scanout.sv - 1-bpp bitmap scan-out with latency-compensated fetch and blinking cursor
//
// Purpose : fetch bitmap words, expand to scaled RGB, overlay cursor, emit
//           pixel-aligned sync/DE. Counter state at t reaches the outputs at t+MEM_LAT+2.
// Ports   : clk, rst (async, active-high)
//           mem_data in / mem_addr, mem_rd out   display memory read port
//           sys_addr in                          forwarded on mem_addr when not fetching
//           cursor_en, cursor_addr in            word-cursor overlay control
//           hsync, vsync, de, rgb, frame_start   registered video outputs
module bitmap_scanout
  import video_scan_pkg::*;
#(
  parameter int   H_ACTIVE     = DEF_H_ACTIVE,
  parameter int   H_FP         = DEF_H_FP,
  parameter int   H_SYNC       = DEF_H_SYNC,
  parameter int   H_BP         = DEF_H_BP,
  parameter int   V_ACTIVE     = DEF_V_ACTIVE,
  parameter int   V_FP         = DEF_V_FP,
  parameter int   V_SYNC       = DEF_V_SYNC,
  parameter int   V_BP         = DEF_V_BP,
  parameter bit   HSYNC_POL    = 1'b1,
  parameter bit   VSYNC_POL    = 1'b1,
  parameter int   WORD_W       = 32,
  parameter int   SCALE_X      = 2,
  parameter int   SCALE_Y      = 2,
  parameter int   MEM_LAT      = 1,
  parameter int   ADDR_W       = 16,
  parameter int   MEM_OFFSET   = 0,
  parameter rgb_t FG_RGB       = DEF_FG_RGB,
  parameter rgb_t BG_RGB       = DEF_BG_RGB,
  parameter int   BLINK_FRAMES = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [ADDR_W-1:0] sys_addr,
  input  logic              cursor_en,
  input  logic [ADDR_W-1:0] cursor_addr,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [23:0]       rgb,
  output logic              frame_start
);

  localparam int PPW = WORD_W * SCALE_X;
  localparam int WPL = words_per_line(H_ACTIVE, WORD_W, SCALE_X);
  localparam int XW  = cnt_width(timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
  localparam int YW  = cnt_width(timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
  localparam int IW  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int FW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES + 1) : 1;

  logic [XW-1:0] w_x;
  logic [YW-1:0] w_y;
  logic          w_active, w_hs, w_vs, w_first;

  video_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .i_clk   (clk),
    .i_rst   (rst),
    .o_x     (w_x),
    .o_y     (w_y),
    .o_active(w_active),
    .o_hsync (w_hs),
    .o_vsync (w_vs),
    .o_first (w_first)
  );

  // Fetch address and bit index, derived from the counter state.
  logic [31:0]       w_row, w_col, w_sub;
  logic              w_fetch;
  logic [ADDR_W-1:0] w_fetch_addr;
  logic [IW-1:0]     w_bit_idx;

  assign w_row        = 32'(w_y) / 32'(SCALE_Y);
  assign w_col        = 32'(w_x) / 32'(PPW);
  assign w_sub        = 32'(w_x) % 32'(PPW);
  assign w_fetch      = w_active && (w_sub == 32'd0);
  assign w_fetch_addr = ADDR_W'(32'(MEM_OFFSET) + w_row * 32'(WPL) + w_col);
  assign w_bit_idx    = IW'(w_sub / 32'(SCALE_X));

  // Blink state. r_phase flips on output frame_start; r_phase_frame holds the
  // phase used by fetches so a toggle only lands at the next (0,0).
  logic [FW-1:0] r_frame_cnt;
  logic          r_phase, r_phase_frame;
  logic          w_phase_eff, w_hit;

  assign w_phase_eff = w_first ? r_phase : r_phase_frame;
  assign w_hit       = cursor_en && (w_fetch_addr == cursor_addr) &&
                       ((BLINK_FRAMES == 0) || w_phase_eff);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt   <= '0;
      r_phase       <= 1'b0;
      r_phase_frame <= 1'b0;
    end else begin
      if (w_first) r_phase_frame <= r_phase;
      if ((BLINK_FRAMES > 0) && frame_start) begin
        if (r_frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          r_frame_cnt <= '0;
          r_phase     <= ~r_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + FW'(1);
        end
      end
    end
  end

  // Address register plus control delay line. Entry 0 is aligned with
  // mem_addr; entry MEM_LAT is aligned with the returning mem_data.
  pipe_ctl_t     r_ctl [0:MEM_LAT];
  logic [IW-1:0] r_idx [0:MEM_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      for (int i = 0; i <= MEM_LAT; i++) begin
        r_ctl[i] <= '0;
        r_idx[i] <= '0;
      end
    end else begin
      mem_addr <= w_fetch ? w_fetch_addr : sys_addr;
      mem_rd   <= w_fetch;
      r_ctl[0] <= '{de: w_active, hs: w_hs, vs: w_vs, fs: w_first,
                    fetch: w_fetch, hit: w_fetch && w_hit};
      r_idx[0] <= w_bit_idx;
      for (int i = 1; i <= MEM_LAT; i++) begin
        r_ctl[i] <= r_ctl[i-1];
        r_idx[i] <= r_idx[i-1];
      end
    end
  end

  // Output stage: on a fetch slot the fresh mem_data is used directly so the
  // word's first pixel costs no extra cycle; later pixels read the held copy.
  pipe_ctl_t         w_out;
  logic [WORD_W-1:0] r_word, w_word;
  logic              r_hit, w_hit_cur, w_bit;

  assign w_out     = r_ctl[MEM_LAT];
  assign w_word    = w_out.fetch ? mem_data : r_word;
  assign w_hit_cur = w_out.fetch ? w_out.hit : r_hit;
  assign w_bit     = w_word[r_idx[MEM_LAT]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word      <= '0;
      r_hit       <= 1'b0;
      de          <= 1'b0;
      rgb         <= '0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      frame_start <= 1'b0;
    end else begin
      if (w_out.fetch) begin
        r_word <= mem_data;
        r_hit  <= w_out.hit;
      end
      de          <= w_out.de;
      rgb         <= w_out.de ? ((w_bit ^ w_hit_cur) ? FG_RGB : BG_RGB) : '0;
      hsync       <= w_out.hs ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= w_out.vs ? VSYNC_POL : ~VSYNC_POL;
      frame_start <= w_out.fs;
    end
  end

endmodule
